iob_system_sim_console: RTL and testbench

Simulation-side console model of the iob_system wrapper.
- Exposes the system UART CSR set on an IOb slave port driven by the simulation bench.
- Contains one 8N1 UART whose serial TX line is looped back internally to its RX line, standing in for the SoC.
- Every byte the bench transmits is received back and becomes readable as RX data.

---
 rtl/iob_system_sim_console_if.sv | 29 ++
 rtl/iob_system_sim_console.sv | 254 +++++++++++++++++++++++++
 tb/tb_iob_system_sim_console.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/iob_system_sim_console_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_system_sim_console_if
// Brief    : IOb request/response bundle between the bench and the console.
// Revision : 1.0
// ============================================================================
interface iob_system_sim_console_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              uart_iob_valid_i;
  logic [ADDR_W-1:0] uart_iob_addr_i;
  logic [DATA_W-1:0] uart_iob_wdata_i;
  logic [3:0]        uart_iob_wstrb_i;
  logic [DATA_W-1:0] uart_iob_rdata_o;
  logic              uart_iob_ready_o;
  logic              uart_iob_rvalid_o;

  modport master (
    output uart_iob_valid_i, uart_iob_addr_i, uart_iob_wdata_i, uart_iob_wstrb_i,
    input  uart_iob_rdata_o, uart_iob_ready_o, uart_iob_rvalid_o
  );

  modport slave (
    input  uart_iob_valid_i, uart_iob_addr_i, uart_iob_wdata_i, uart_iob_wstrb_i,
    output uart_iob_rdata_o, uart_iob_ready_o, uart_iob_rvalid_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_system_sim_console.sv
`default_nettype none
// ============================================================================
// Module   : iob_system_sim_console
// Brief    : UART CSR block on an IOb slave with TX looped back into RX.
// Revision : 1.0
// ============================================================================
module iob_system_sim_console #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  wire logic               clk_i,
  input  wire logic               arst_i,
  input  wire logic               cke_i,
  iob_system_sim_console_if.slave uart_iob
);

  localparam logic [ADDR_W-1:0] c_ADDR_SOFTRESET = 4'd0;
  localparam logic [ADDR_W-1:0] c_ADDR_DIV       = 4'd2;
  localparam logic [ADDR_W-1:0] c_ADDR_TXDATA    = 4'd4;
  localparam logic [ADDR_W-1:0] c_ADDR_TXEN      = 4'd5;
  localparam logic [ADDR_W-1:0] c_ADDR_RXEN      = 4'd6;
  localparam logic [ADDR_W-1:0] c_ADDR_TXREADY   = 4'd8;
  localparam logic [ADDR_W-1:0] c_ADDR_RXREADY   = 4'd9;
  localparam logic [ADDR_W-1:0] c_ADDR_RXDATA    = 4'd10;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // CSR state
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_softreset;
  logic [15:0]       r_div;
  logic              r_txen;
  logic              r_rxen;

  // TX engine
  logic              r_tx_busy;
  logic [9:0]        r_tx_shift;
  logic [15:0]       r_tx_cnt;
  logic [3:0]        r_tx_bits;

  // RX engine
  rx_state_t         r_rx_state;
  rx_state_t         w_rx_next;
  logic [15:0]       r_rx_cnt;
  logic [2:0]        r_rx_bit;
  logic [7:0]        r_rx_shift;
  logic              r_rx_prev;
  logic              r_rxready;
  logic [7:0]        r_rxdata;

  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_rdata;
  logic              w_tx_start;
  logic              w_line;
  logic [15:0]       w_div_eff;
  logic [15:0]       w_half;
  logic              w_rxdata_rd;
  logic              w_rx_shift_en;
  logic              w_rx_done;
  logic              w_rx_cnt_clr;
  logic              w_unused;

  assign w_addr   = uart_iob.uart_iob_addr_i;
  assign w_wdata  = uart_iob.uart_iob_wdata_i;
  assign w_wstrb  = uart_iob.uart_iob_wstrb_i;
  assign w_accept = uart_iob.uart_iob_valid_i & cke_i;
  assign w_wr     = w_accept & (|w_wstrb);
  assign w_rd     = w_accept & ~(|w_wstrb);
  assign w_unused = ^w_wdata[15:9];

  assign uart_iob.uart_iob_ready_o  = cke_i;
  assign uart_iob.uart_iob_rvalid_o = r_rvalid;
  assign uart_iob.uart_iob_rdata_o  = r_rdata;

  // A divider of 0 or 1 both mean one clock per bit
  assign w_div_eff   = (r_div < 16'd2) ? 16'd1 : r_div;
  assign w_half      = w_div_eff >> 1;
  assign w_line      = r_tx_busy ? r_tx_shift[0] : 1'b1;
  assign w_tx_start  = w_wr && (w_addr == c_ADDR_TXDATA) && w_wstrb[0] &&
                       r_txen && !r_tx_busy && !r_softreset;
  assign w_rxdata_rd = w_rd && (w_addr == c_ADDR_RXDATA);

  always_comb begin
    w_rdata = '0;
    unique case (w_addr)
      c_ADDR_DIV:     w_rdata = {r_div, 16'h0000};
      c_ADDR_TXREADY: w_rdata = {31'd0, ~r_tx_busy};
      c_ADDR_RXREADY: w_rdata = {23'd0, r_rxready, 8'h00};
      c_ADDR_RXDATA:  w_rdata = {8'h00, r_rxdata, 16'h0000};
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_softreset <= 1'b0;
      r_div       <= 16'd0;
      r_txen      <= 1'b0;
      r_rxen      <= 1'b0;
    end else if (cke_i) begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
      if (w_wr) begin
        if (w_addr == c_ADDR_SOFTRESET && w_wstrb[0]) r_softreset <= w_wdata[0];
        if (w_addr == c_ADDR_DIV && w_wstrb[2])       r_div[7:0]  <= w_wdata[23:16];
        if (w_addr == c_ADDR_DIV && w_wstrb[3])       r_div[15:8] <= w_wdata[31:24];
        if (w_addr == c_ADDR_TXEN && w_wstrb[1])      r_txen      <= w_wdata[8];
        if (w_addr == c_ADDR_RXEN && w_wstrb[2])      r_rxen      <= w_wdata[16];
      end
    end
  end

  // Frame is {stop, data[7:0], start}, shifted out LSB first
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_cnt   <= 16'd1;
      r_tx_bits  <= 4'd0;
    end else if (cke_i) begin
      if (r_softreset) begin
        r_tx_busy  <= 1'b0;
        r_tx_shift <= '1;
        r_tx_cnt   <= 16'd1;
        r_tx_bits  <= 4'd0;
      end else if (w_tx_start) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, w_wdata[7:0], 1'b0};
        r_tx_cnt   <= 16'd1;
        r_tx_bits  <= 4'd9;
      end else if (r_tx_busy) begin
        if (r_tx_cnt >= w_div_eff) begin
          r_tx_cnt <= 16'd1;
          if (r_tx_bits == 4'd0) begin
            r_tx_busy <= 1'b0;
          end else begin
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            r_tx_bits  <= r_tx_bits - 4'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
    end
  end

  // With a one-cycle bit the edge detection itself confirms the start bit
  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_shift_en = 1'b0;
    w_rx_done     = 1'b0;
    w_rx_cnt_clr  = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !w_line) begin
          w_rx_cnt_clr = 1'b1;
          w_rx_next    = (w_half == 16'd0) ? RX_DATA : RX_START;
        end
      end
      RX_START: begin
        if (r_rx_cnt >= w_half) begin
          w_rx_cnt_clr = 1'b1;
          w_rx_next    = w_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt >= w_div_eff) begin
          w_rx_cnt_clr  = 1'b1;
          w_rx_shift_en = 1'b1;
          if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt >= w_div_eff) begin
          w_rx_done = 1'b1;
          w_rx_next = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
    if (!r_rxen || r_softreset) begin
      w_rx_next     = RX_IDLE;
      w_rx_shift_en = 1'b0;
      w_rx_done     = 1'b0;
      w_rx_cnt_clr  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rx_state <= RX_IDLE;
    end else if (cke_i) begin
      r_rx_state <= w_rx_next;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rx_cnt   <= 16'd1;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_prev  <= 1'b1;
    end else if (cke_i) begin
      r_rx_prev <= r_softreset ? 1'b1 : w_line;
      if (w_rx_cnt_clr || r_rx_state == RX_IDLE || r_softreset) begin
        r_rx_cnt <= 16'd1;
      end else begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
      if (r_rx_state == RX_IDLE || r_softreset) begin
        r_rx_bit <= 3'd0;
      end else if (w_rx_shift_en) begin
        r_rx_shift <= {w_line, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  // A byte landing in the same cycle as an RXDATA read keeps RXREADY set
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rxready <= 1'b0;
      r_rxdata  <= 8'h00;
    end else if (cke_i) begin
      if (r_softreset) begin
        r_rxready <= 1'b0;
        r_rxdata  <= 8'h00;
      end else begin
        if (w_rxdata_rd) r_rxready <= 1'b0;
        if (w_rx_done) begin
          r_rxready <= 1'b1;
          r_rxdata  <= r_rx_shift;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_system_sim_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_system_sim_console
// Brief    : Directed scoreboard bench for the looped-back UART console.
// Revision : 1.0
// ============================================================================
module tb_iob_system_sim_console;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
    logic [3:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cke;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  exp_t        e;
  int unsigned w;

  iob_system_sim_console_if #(.DATA_W(32), .ADDR_W(4)) iob ();

  iob_system_sim_console #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk_i    (clk),
    .arst_i   (arst_n),
    .cke_i    (cke),
    .uart_iob (iob.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Read responses must arrive in the cycle right after their accept edge
  always @(negedge clk) begin
    if (arst_n && iob.uart_iob_rvalid_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid rdata=%h required no response", iob.uart_iob_rdata_o);
      end else begin
        e = sb.pop_front();
        if (iob.uart_iob_rdata_o !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL read_addr%0d got rdata=%h cyc=%0d required rdata=%h cyc=%0d",
                   e.addr, iob.uart_iob_rdata_o, cyc, e.data, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL missing_rvalid addr%0d got none required rdata=%h", e.addr, e.data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp);
    iob.uart_iob_valid_i = 1'b1;
    iob.uart_iob_addr_i  = a;
    iob.uart_iob_wdata_i = d;
    iob.uart_iob_wstrb_i = s;
    @(posedge clk);
    #1;
    if (s == 4'd0) sb.push_back('{data: exp, cyc: cyc, addr: a});
    iob.uart_iob_valid_i = 1'b0;
    iob.uart_iob_wstrb_i = 4'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    req(a, d, s, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    req(a, 32'h0, 4'd0, exp);
  endtask

  // Position so the next request is accepted at edge t
  task automatic at(input int unsigned t);
    while (cyc + 1 < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    iob.uart_iob_valid_i = 1'b0;
    iob.uart_iob_addr_i  = 4'd0;
    iob.uart_iob_wdata_i = 32'h0;
    iob.uart_iob_wstrb_i = 4'd0;
    cke    = 1'b1;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", {31'd0, iob.uart_iob_rvalid_o}, 32'd0);
    chk("reset_rdata", iob.uart_iob_rdata_o, 32'd0);
    chk("ready_with_cke", {31'd0, iob.uart_iob_ready_o}, 32'd1);
    arst_n = 1'b1;
    waitn(2);

    // Reset values of every CSR
    rd(4'd8,  32'h0000_0001);
    rd(4'd9,  32'h0000_0000);
    rd(4'd10, 32'h0000_0000);
    rd(4'd2,  32'h0000_0000);
    rd(4'd3,  32'h0000_0000);

    // Init and first loopback byte
    wr(4'd0, 32'h1, 4'b0001);
    wr(4'd0, 32'h0, 4'b0001);
    wr(4'd2, 32'h0004_0000, 4'b1100);
    wr(4'd6, 32'h0001_0000, 4'b0100);
    wr(4'd5, 32'h0000_0100, 4'b0010);
    rd(4'd2, 32'h0004_0000);
    wr(4'd4, 32'h41, 4'b0001);
    w = cyc;
    at(w + 1);  rd(4'd8, 32'h0);
    at(w + 36); rd(4'd9, 32'h0);
    at(w + 40); rd(4'd8, 32'h0);
    at(w + 41); rd(4'd8, 32'h1);
    at(w + 42); rd(4'd9, 32'h100);
    rd(4'd10, 32'h0041_0000);
    rd(4'd9,  32'h0);

    // TXDATA is ignored while TXEN=0
    wr(4'd5, 32'h0, 4'b0010);
    wr(4'd4, 32'h55, 4'b0001);
    rd(4'd8, 32'h1);
    waitn(100);
    rd(4'd8, 32'h1);
    rd(4'd9, 32'h0);

    // Overrun: second byte overwrites the first
    wr(4'd5, 32'h0000_0100, 4'b0010);
    wr(4'd4, 32'h12, 4'b0001);
    waitn(45);
    wr(4'd4, 32'h34, 4'b0001);
    waitn(45);
    rd(4'd9,  32'h100);
    rd(4'd10, 32'h0034_0000);
    rd(4'd9,  32'h0);

    // SOFTRESET mid-frame aborts everything and clears RX flags
    wr(4'd4, 32'hFF, 4'b0001);
    waitn(10);
    wr(4'd0, 32'h1, 4'b0001);
    wr(4'd0, 32'h0, 4'b0001);
    waitn(50);
    rd(4'd8,  32'h1);
    rd(4'd9,  32'h0);
    rd(4'd10, 32'h0);

    // Clock-enable stall for 20 cycles mid-frame
    wr(4'd4, 32'h5A, 4'b0001);
    w = cyc;
    at(w + 11);
    cke = 1'b0;
    iob.uart_iob_valid_i = 1'b1;
    iob.uart_iob_addr_i  = 4'd8;
    iob.uart_iob_wstrb_i = 4'd0;
    @(negedge clk);
    chk("ready_without_cke", {31'd0, iob.uart_iob_ready_o}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    iob.uart_iob_valid_i = 1'b0;
    cke = 1'b1;
    at(w + 60); rd(4'd8, 32'h0);
    at(w + 61); rd(4'd8, 32'h1);
    rd(4'd9,  32'h100);
    rd(4'd10, 32'h005A_0000);

    waitn(5);
    chk("scoreboard_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
